// File: rtl/fifo_sram_pkg.sv
// Definitions shared by the fifo_sram family: default word width and the
// beat-to-bit-offset mapping used when slicing a FIFO word into narrower beats.
package fifo_sram_pkg;

  localparam int FIFO_DEF_WIDTH = 128;

  // Bit offset of the given beat inside a word of `ratio` beats, each `width` bits wide.
  function automatic int unsigned slice_idx(input int unsigned beat,
                                            input bit          lsb_first,
                                            input int unsigned ratio,
                                            input int unsigned width);
    return lsb_first ? beat * width : (ratio - 1 - beat) * width;
  endfunction

endpackage

// File: rtl/fifo_rd_downsizer.sv
// Read-side consumer for fifo_sram: pops one wide word and replays it as
// IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream, one beat per clock.
module fifo_rd_downsizer
  import fifo_sram_pkg::*;
#(
  parameter int IN_WIDTH  = FIFO_DEF_WIDTH,
  parameter int OUT_WIDTH = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  input  logic                 fifo_rd_empty,
  output logic                 fifo_rd_en,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OFF_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_chk
    $error("fifo_rd_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic                hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic                acc, done;
  logic [OFF_W-1:0]    slice_off;

  assign acc  = hold_vld_q & out_ready;
  assign done = acc & (beat_q == LAST_BEAT);

  // The pop is gated by rstb so nothing is consumed while the block is held in reset.
  assign fifo_rd_en = rstb & ~fifo_rd_empty & (~hold_vld_q | done);

  assign slice_off = OFF_W'(slice_idx(32'(beat_q), LSB_FIRST, RATIO, OUT_WIDTH));
  assign out_data  = hold_q[slice_off +: OUT_WIDTH];
  assign out_valid = hold_vld_q;
  assign out_last  = hold_vld_q & (beat_q == LAST_BEAT);
  assign busy      = hold_vld_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    hold_vld_d = hold_vld_q;
    beat_d     = beat_q;
    hold_d     = hold_q;
    if (fifo_rd_en) begin
      hold_d     = fifo_rd_data;
      hold_vld_d = 1'b1;
      beat_d     = '0;
    end else if (done) begin
      hold_vld_d = 1'b0;
      beat_d     = '0;
    end else if (acc) begin
      beat_d = beat_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hold_vld_q <= 1'b0;
      beat_q     <= '0;
      // NOTE: the word register is reset too, so out_data reads zero after reset.
      hold_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      hold_vld_q <= hold_vld_d;
      beat_q     <= beat_d;
      hold_q     <= hold_d;
    end
  end

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rstb)
    fifo_rd_en |-> !fifo_rd_empty);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rstb)
    (out_valid && !out_ready) |=> $stable({out_data, out_last}));

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Bench for fifo_rd_downsizer: directed vector table on a 128->32 instance plus
// randomized runs on 128->32, 128->64 (MSB first) and 128->128 against a reassembling scoreboard.
module tb_fifo_rd_downsizer;

  localparam int IW = 128;
  localparam int MW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit rnd_done [3];

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- directed instance: 128 -> 32, LSB first ----------------
  logic          m_rstb, m_empty, m_en, m_valid, m_ready, m_last, m_busy;
  logic [IW-1:0] m_data;
  logic [MW-1:0] m_out;

  fifo_rd_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(MW), .LSB_FIRST(1'b1)) u_dut (
    .clk          (clk),
    .rstb         (m_rstb),
    .fifo_rd_data (m_data),
    .fifo_rd_empty(m_empty),
    .fifo_rd_en   (m_en),
    .out_data     (m_out),
    .out_valid    (m_valid),
    .out_ready    (m_ready),
    .out_last     (m_last),
    .busy         (m_busy)
  );

  logic [IW-1:0] mq [$];
  bit            m_pop;

  // One clock: apply the pop seen last cycle, drive inputs, then sample at the falling edge.
  task automatic tick(input bit rdy);
    @(posedge clk);
    #1;
    if (m_pop) void'(mq.pop_front());
    m_ready = rdy;
    m_empty = (mq.size() == 0);
    m_data  = m_empty ? {$urandom, $urandom, $urandom, $urandom} : mq[0];
    @(negedge clk);
    m_pop = m_en;
  endtask

  typedef struct packed {
    bit            push;
    logic [IW-1:0] word;
    bit            rdy;
    bit            valid;
    logic [MW-1:0] data;
    bit            last;
    bit            en;
  } vec_t;

  function automatic vec_t mk(input bit push, input logic [IW-1:0] word, input bit rdy,
                              input bit valid, input logic [MW-1:0] data, input bit last,
                              input bit en);
    vec_t v;
    v.push = push; v.word = word; v.rdy = rdy;
    v.valid = valid; v.data = data; v.last = last; v.en = en;
    return v;
  endfunction

  localparam logic [IW-1:0] W0 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [IW-1:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [IW-1:0] W2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [IW-1:0] W3 = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
  localparam logic [IW-1:0] W4 = 128'h44443333_22221111_BEEF0002_CAFE0001;
  localparam logic [IW-1:0] W5 = 128'h12345678_9ABCDEF0_0F1E2D3C_600DF00D;

  vec_t vt [28];

  initial begin
    // push, word, rdy | valid, data, last, en  (data ignored when valid=0)
    vt[0]  = mk(1, W1, 1, 1, 32'hAAAAAAAA, 0, 0);
    vt[1]  = mk(1, W2, 1, 1, 32'hBBBBBBBB, 0, 0);
    vt[2]  = mk(0, '0, 1, 1, 32'hCCCCCCCC, 0, 0);
    vt[3]  = mk(0, '0, 1, 1, 32'hDDDDDDDD, 1, 1);
    vt[4]  = mk(0, '0, 1, 1, 32'h11111111, 0, 0);
    vt[5]  = mk(0, '0, 1, 1, 32'h22222222, 0, 0);
    vt[6]  = mk(0, '0, 1, 1, 32'h33333333, 0, 0);
    vt[7]  = mk(0, '0, 1, 1, 32'h44444444, 1, 1);
    vt[8]  = mk(0, '0, 1, 1, 32'h55555555, 0, 0);
    vt[9]  = mk(0, '0, 1, 1, 32'h66666666, 0, 0);
    for (int i = 10; i < 15; i++) vt[i] = mk(0, '0, 0, 1, 32'h77777777, 0, 0);
    vt[15] = mk(0, '0, 1, 1, 32'h77777777, 0, 0);
    vt[16] = mk(1, W3, 0, 1, 32'h88888888, 1, 0);
    vt[17] = mk(0, '0, 0, 1, 32'h88888888, 1, 0);
    vt[18] = mk(0, '0, 1, 1, 32'h88888888, 1, 1);
    vt[19] = mk(0, '0, 1, 1, 32'h0A0A0A0A, 0, 0);
    vt[20] = mk(0, '0, 1, 1, 32'h0B0B0B0B, 0, 0);
    vt[21] = mk(0, '0, 1, 1, 32'h0C0C0C0C, 0, 0);
    vt[22] = mk(0, '0, 1, 1, 32'h0D0D0D0D, 1, 0);
    vt[23] = mk(0, '0, 1, 0, 32'h0,        0, 0);
    vt[24] = mk(0, '0, 1, 0, 32'h0,        0, 0);
    vt[25] = mk(1, W4, 1, 0, 32'h0,        0, 1);
    vt[26] = mk(0, '0, 1, 1, 32'hCAFE0001, 0, 0);
    vt[27] = mk(0, '0, 0, 1, 32'hBEEF0002, 0, 0);

    // T1: reset with a non-empty FIFO, then release
    m_rstb = 1'b0; m_ready = 1'b0; m_empty = 1'b1; m_data = '0; m_pop = 1'b0;
    mq.push_back(W0);
    tick(0);
    check("t1_rst_en",    m_en,    0);
    check("t1_rst_valid", m_valid, 0);
    check("t1_rst_data",  m_out,   0);
    check("t1_rst_last",  m_last,  0);
    check("t1_rst_busy",  m_busy,  0);
    m_rstb = 1'b1;
    #1;
    m_pop = m_en;
    check("t1_release_en",    m_en,    1);
    check("t1_release_valid", m_valid, 0);
    tick(0);
    check("t1_first_valid", m_valid, 1);
    check("t1_first_data",  m_out,   32'hAAAAAAAA);
    check("t1_first_en",    m_en,    0);

    // T2-T4 and T5 starvation: vector table
    foreach (vt[i]) begin
      if (vt[i].push) mq.push_back(vt[i].word);
      tick(vt[i].rdy);
      check($sformatf("vec%0d_valid", i), m_valid, vt[i].valid);
      check($sformatf("vec%0d_busy", i),  m_busy,  vt[i].valid);
      check($sformatf("vec%0d_last", i),  m_last,  vt[i].last);
      check($sformatf("vec%0d_en", i),    m_en,    vt[i].en);
      if (vt[i].valid) check($sformatf("vec%0d_data", i), m_out, vt[i].data);
    end

    // T5: async reset mid-word with the FIFO non-empty; remainder of W4 is lost
    mq.push_back(W5);
    #2;
    m_rstb = 1'b0;
    #1;
    m_pop = m_en;
    check("t5_async_valid", m_valid, 0);
    check("t5_async_data",  m_out,   0);
    check("t5_async_last",  m_last,  0);
    check("t5_async_busy",  m_busy,  0);
    check("t5_async_en",    m_en,    0);
    tick(1);
    check("t5_held_en",    m_en,    0);
    check("t5_held_valid", m_valid, 0);
    m_rstb = 1'b1;
    #1;
    m_pop = m_en;
    check("t5_release_en", m_en, 1);
    tick(1);
    check("t5_after_valid", m_valid, 1);
    check("t5_after_data",  m_out,   32'h600DF00D);
    check("t5_after_last",  m_last,  0);

    // wait for the randomized runs, bounded
    for (int i = 0; i < 60000 && !(rnd_done[0] && rnd_done[1] && rnd_done[2]); i++)
      @(posedge clk);
    check("rnd_all_finished", {rnd_done[0], rnd_done[1], rnd_done[2]}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- randomized instances: RATIO 4, 2 (MSB first), 1 ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int OW = (g == 0) ? 32 : (g == 1) ? 64 : 128;
    localparam bit LF = (g != 1);
    localparam int R  = IW / OW;
    localparam int NW = 1000;

    logic          r_rstb, r_empty, r_en, r_valid, r_ready, r_last, r_busy;
    logic [IW-1:0] r_data;
    logic [OW-1:0] r_out;

    fifo_rd_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(LF)) u_dut (
      .clk          (clk),
      .rstb         (r_rstb),
      .fifo_rd_data (r_data),
      .fifo_rd_empty(r_empty),
      .fifo_rd_en   (r_en),
      .out_data     (r_out),
      .out_valid    (r_valid),
      .out_ready    (r_ready),
      .out_last     (r_last),
      .busy         (r_busy)
    );

    initial begin
      logic [IW-1:0] fq [$];
      logic [IW-1:0] wlog [$];
      logic [IW-1:0] asm_w, w, exp_w;
      logic [OW-1:0] prev_out;
      int pushed, got, k;
      bit pop, prev_stall, prev_last;
      pushed = 0; got = 0; k = 0; pop = 0; prev_stall = 0; prev_last = 0;
      asm_w = '0; prev_out = '0;
      r_rstb = 1'b0; r_ready = 1'b0; r_empty = 1'b1; r_data = '0;
      repeat (2) @(posedge clk);
      #1 r_rstb = 1'b1;
      for (int cyc = 0; cyc < 40000 && got < NW; cyc++) begin
        @(posedge clk);
        #1;
        if (pop) void'(fq.pop_front());
        if (pushed < NW && $urandom_range(0, 2 * R) < 2) begin
          w = {$urandom, $urandom, $urandom, $urandom};
          fq.push_back(w);
          wlog.push_back(w);
          pushed++;
        end
        r_empty = (fq.size() == 0);
        r_data  = r_empty ? {$urandom, $urandom, $urandom, $urandom} : fq[0];
        r_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (r_empty) check($sformatf("rnd%0d_pop_while_empty", g), r_en, 0);
        check($sformatf("rnd%0d_busy", g), r_busy, r_valid);
        if (prev_stall)
          check($sformatf("rnd%0d_stall_stable", g), {r_last, r_out}, {prev_last, prev_out});
        if (r_valid && r_ready) begin
          check($sformatf("rnd%0d_last_beat%0d", g, k), r_last, (k == R - 1));
          asm_w[(LF ? k : R - 1 - k) * OW +: OW] = r_out;
          k++;
          if (k == R) begin
            exp_w = (wlog.size() != 0) ? wlog.pop_front() : 'x;
            check($sformatf("rnd%0d_word%0d", g, got), asm_w, exp_w);
            got++;
            k = 0;
          end
        end
        pop        = r_en;
        prev_stall = r_valid & ~r_ready;
        prev_out   = r_out;
        prev_last  = r_last;
      end
      check($sformatf("rnd%0d_words_done", g), got, NW);
      rnd_done[g] = 1'b1;
    end
  end

endmodule
